// File: rtl/car_motion_ctrl.sv
// Car physics: integrates a 2-bit accel code into a saturating signed velocity
// and a clamped horizontal position, once per prescaled physics tick.
module car_motion_ctrl #(
  parameter int TICK_DIV       = 833333,
  parameter int VMAX           = 15,
  parameter int FRICTION_TICKS = 4,
  parameter int POS_MAX        = 639,
  parameter int POS_INIT       = 320
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        accel,
  input  logic              enable,
  output logic signed [4:0] velocity,
  output logic [9:0]        position,
  output logic              tick,
  output logic              at_limit,
  output logic              moving
);

  localparam logic [19:0]        C_DIV_LAST = 20'(TICK_DIV - 1);
  localparam logic signed [4:0]  C_VMAX     = 5'(VMAX);
  localparam logic signed [11:0] C_POS_MAX  = 12'(POS_MAX);
  localparam logic [9:0]         C_POS_INIT = 10'(POS_INIT);
  localparam logic [3:0]         C_FRIC     = 4'(FRICTION_TICKS);

  logic [19:0]        r_presc;
  logic signed [4:0]  r_vel;
  logic [9:0]         r_pos;
  logic [3:0]         r_coast;
  logic               r_tick;
  logic               r_lim;

  logic               w_wrap;
  logic signed [11:0] w_sum;
  logic               w_clamp;
  logic [9:0]         w_pos_nxt;
  logic signed [4:0]  w_vel_nxt;
  logic [3:0]         w_coast_nxt;

  assign w_wrap = (r_presc == C_DIV_LAST);
  assign w_sum  = $signed({2'b00, r_pos}) + $signed({{7{r_vel[4]}}, r_vel});

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_clamp   = 1'b0;
    w_pos_nxt = w_sum[9:0];
    if (w_sum < 12'sd0) begin
      w_clamp   = 1'b1;
      w_pos_nxt = '0;
    end else if (w_sum > C_POS_MAX) begin
      w_clamp   = 1'b1;
      w_pos_nxt = C_POS_MAX[9:0];
    end
  end

  // A clamp zeroes velocity regardless of the requested acceleration.
  always_comb begin
    w_vel_nxt   = r_vel;
    w_coast_nxt = '0;
    if (w_clamp) begin
      w_vel_nxt = '0;
    end else begin
      case (accel)
        2'b10: if (r_vel < C_VMAX) w_vel_nxt = r_vel + 5'sd1;
        2'b01: if (r_vel > -C_VMAX) w_vel_nxt = r_vel - 5'sd1;
        2'b11: begin
          if (r_vel > 5'sd2)       w_vel_nxt = r_vel - 5'sd2;
          else if (r_vel < -5'sd2) w_vel_nxt = r_vel + 5'sd2;
          else                     w_vel_nxt = '0;
        end
        default: begin
          if ((r_coast + 4'd1) == C_FRIC) begin
            w_coast_nxt = '0;
            if (r_vel > 5'sd0)      w_vel_nxt = r_vel - 5'sd1;
            else if (r_vel < 5'sd0) w_vel_nxt = r_vel + 5'sd1;
          end else begin
            w_coast_nxt = r_coast + 4'd1;
          end
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_presc <= '0;
      r_vel   <= '0;
      r_pos   <= C_POS_INIT;
      r_coast <= '0;
      r_tick  <= 1'b0;
      r_lim   <= 1'b0;
    end else if (enable) begin
      r_tick <= w_wrap;
      r_lim  <= w_wrap & w_clamp;
      if (w_wrap) begin
        r_presc <= '0;
        r_pos   <= w_pos_nxt;
        r_vel   <= w_vel_nxt;
        r_coast <= w_coast_nxt;
      end else begin
        r_presc <= r_presc + 20'd1;
      end
    end else begin
      r_tick <= 1'b0;
      r_lim  <= 1'b0;
    end
  end

  assign velocity = r_vel;
  assign position = r_pos;
  assign tick     = r_tick;
  assign at_limit = r_lim;
  assign moving   = (r_vel != 5'sd0);

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Scoreboard bench for car_motion_ctrl: stimulus queues hand-computed per-tick
// results, a negedge monitor pops and compares them whenever tick is high.
module tb_car_motion_ctrl;

  typedef struct {
    int   v;
    int   p;
    logic lim;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        accel;
  logic              enable;
  logic signed [4:0] velocity;
  logic [9:0]        position;
  logic              tick;
  logic              at_limit;
  logic              moving;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_no = 0;
  int   last_v = 0;
  int   last_p = 320;

  car_motion_ctrl #(
    .TICK_DIV(4), .VMAX(15), .FRICTION_TICKS(4), .POS_MAX(639), .POS_INIT(320)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .accel   (accel),
    .enable  (enable),
    .velocity(velocity),
    .position(position),
    .tick    (tick),
    .at_limit(at_limit),
    .moving  (moving)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: at_limit only ever alongside tick; each tick consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    check("at_limit without tick", int'(at_limit & ~tick), 0);
    if (tick) begin
      tick_no++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected tick %0d: got tick with empty scoreboard", tick_no);
      end else begin
        e = sb.pop_front();
        check($sformatf("t%0d velocity", tick_no), int'(velocity), e.v);
        check($sformatf("t%0d position", tick_no), int'(position), e.p);
        check($sformatf("t%0d at_limit", tick_no), int'(at_limit), int'(e.lim));
        check($sformatf("t%0d moving", tick_no), int'(moving), int'(e.v != 0));
      end
    end
  end

  // Queue one expected tick result, drive accel (optionally toggling it on
  // non-wrap cycles) and verify the tick arrives after exactly `edges` edges.
  task automatic run_tick(input logic [1:0] a, input bit toggle, input int ev,
                          input int ep, input bit el, input int edges);
    bit seen;
    sb.push_back('{ev, ep, el});
    last_v = ev;
    last_p = ep;
    seen   = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (toggle && n < edges - 1) accel = (n % 2 == 0) ? 2'b01 : 2'b11;
      else                         accel = a;
      @(posedge clk);
      #1;
      if (tick) begin
        seen = 1'b1;
        check("tick spacing", n + 1, edges);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL tick timeout: got no tick expected one after %0d edges", edges);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev, ep;
    reset  = 1'b1;
    enable = 1'b1;
    accel  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset velocity", int'(velocity), 0);
    check("reset position", int'(position), 320);
    check("reset tick", int'(tick), 0);
    check("reset at_limit", int'(at_limit), 0);
    check("reset moving", int'(moving), 0);
    reset = 1'b0;

    // Coasting at rest: nothing moves for 8 ticks.
    for (int k = 0; k < 8; k++) run_tick(2'b00, 0, 0, 320, 0, 4);

    // Forward held 20 ticks: ramp to 15 and saturate; tick 5 lands at 330, tick 20 at 500.
    ev = 0;
    ep = 320;
    for (int k = 1; k <= 20; k++) begin
      ep += ev;
      ev = (ev < 15) ? ev + 1 : 15;
      run_tick(2'b10, 0, ev, ep, 0, 4);
    end

    // Down to +6, coast with friction every 4th tick, then brake to 0.
    run_tick(2'b01, 0, 14, 515, 0, 4);
    run_tick(2'b11, 0, 12, 529, 0, 4);
    run_tick(2'b11, 0, 10, 541, 0, 4);
    run_tick(2'b11, 0, 8, 551, 0, 4);
    run_tick(2'b11, 0, 6, 559, 0, 4);
    run_tick(2'b00, 0, 6, 565, 0, 4);
    run_tick(2'b00, 0, 6, 571, 0, 4);
    run_tick(2'b00, 0, 6, 577, 0, 4);
    run_tick(2'b00, 0, 5, 583, 0, 4);
    run_tick(2'b00, 0, 5, 588, 0, 4);
    run_tick(2'b00, 0, 5, 593, 0, 4);
    run_tick(2'b00, 0, 5, 598, 0, 4);
    run_tick(2'b00, 0, 4, 603, 0, 4);
    run_tick(2'b11, 0, 2, 607, 0, 4);
    run_tick(2'b11, 0, 0, 609, 0, 4);
    run_tick(2'b11, 0, 0, 609, 0, 4);

    // accel toggling between ticks, only 10 at the wrap cycle.
    run_tick(2'b10, 1, 1, 609, 0, 4);
    run_tick(2'b10, 1, 2, 610, 0, 4);
    run_tick(2'b10, 1, 3, 612, 0, 4);
    run_tick(2'b10, 1, 4, 615, 0, 4);
    run_tick(2'b10, 1, 5, 619, 0, 4);

    // Freeze with the prescaler at 1: 10 frozen cycles, then 3 edges to the tick.
    @(posedge clk);
    #1;
    enable = 1'b0;
    accel  = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("freeze tick", int'(tick), 0);
      check("freeze velocity", int'(velocity), last_v);
      check("freeze position", int'(position), last_p);
    end
    enable = 1'b1;
    run_tick(2'b10, 1, 6, 624, 0, 3);
    run_tick(2'b10, 1, 7, 630, 0, 4);
    run_tick(2'b10, 1, 8, 637, 0, 4);
    run_tick(2'b10, 1, 0, 639, 1, 4);
    run_tick(2'b10, 1, 1, 639, 0, 4);
    run_tick(2'b01, 0, 0, 639, 1, 4);
    run_tick(2'b01, 0, -1, 639, 0, 4);
    run_tick(2'b01, 0, -2, 638, 0, 4);
    run_tick(2'b01, 0, -3, 636, 0, 4);

    // Reset mid-run with the prescaler at 2.
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrun reset velocity", int'(velocity), 0);
    check("midrun reset position", int'(position), 320);
    check("midrun reset tick", int'(tick), 0);
    reset = 1'b0;

    // Backward from 320: saturate at -15, low clamp on tick 30, resume at -1.
    ev = 0;
    ep = 320;
    for (int k = 1; k <= 29; k++) begin
      ep += ev;
      ev = (ev > -15) ? ev - 1 : -15;
      run_tick(2'b01, 0, ev, ep, 0, 4);
    end
    run_tick(2'b01, 0, 0, 0, 1, 4);
    run_tick(2'b01, 0, -1, 0, 0, 4);
    run_tick(2'b11, 0, 0, 0, 1, 4);
    run_tick(2'b11, 0, 0, 0, 0, 4);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
